// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared types and constants for the 1:2 dispatcher
// Contents: dmux_sel_t destination encoding, drain counter width, default data width.
package dmux_pkg;

  typedef enum logic {
    SEL_Y0 = 1'b0,
    SEL_Y1 = 1'b1
  } dmux_sel_t;

  localparam int DMUX_CNT_W     = 16;
  localparam int DMUX_WIDTH_DEF = 8;

endpackage

// File: rtl/dmux_out_slot.sv
// rtl/dmux_out_slot.sv - one-entry registered output slot with valid/ready handshake
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load, d           write d into the slot this cycle (caller only loads when free)
//   ready             consumer takes the held beat
//   valid, q          slot occupancy and held data
//   free              slot can accept a load this cycle (empty or draining)
//   cnt               drain handshake counter, present only with DMUX_DISP_CNT_EN
module dmux_out_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
`ifdef DMUX_DISP_CNT_EN
  ,
  output logic [DMUX_CNT_W-1:0] cnt
`endif
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = valid_q && ready;
  assign free  = !valid_q || ready;
  assign valid = valid_q;
  assign q     = data_q;

  // A load in the same cycle as a drain wins, so the slot stays valid with new data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef DMUX_DISP_CNT_EN
  logic [DMUX_CNT_W-1:0] cnt_q, cnt_d;

  // Natural wrap from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (drain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/dmux_1by2_dispatcher.sv
// rtl/dmux_1by2_dispatcher.sv - flow-controlled 1-to-2 stream dispatcher
// Optional feature macro: DMUX_DISP_CNT_EN adds per-slot drain counters cnt0/cnt1.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mode, s                     0 = round-robin, 1 = explicit destination s
//   i_data, i_valid, i_ready    input stream
//   y0_data/valid/ready         output slot 0
//   y1_data/valid/ready         output slot 1
//   rr_ptr                      current round-robin target
//   cnt0, cnt1                  drain counters (DMUX_DISP_CNT_EN only)
module dmux_1by2_dispatcher
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic             rr_ptr
`ifdef DMUX_DISP_CNT_EN
  ,
  output logic [DMUX_CNT_W-1:0] cnt0,
  output logic [DMUX_CNT_W-1:0] cnt1
`endif
);

  logic      rr_ptr_q, rr_ptr_d;
  dmux_sel_t tgt;
  logic      free0, free1;
  logic      accept;
  logic      load0, load1;

  // No skipping: only the chosen target's freedom matters, never the other slot.
  always_comb begin
    tgt     = mode ? dmux_sel_t'(s) : dmux_sel_t'(rr_ptr_q);
    i_ready = (tgt == SEL_Y1) ? free1 : free0;
    accept  = i_valid && i_ready;
    load0   = accept && (tgt == SEL_Y0);
    load1   = accept && (tgt == SEL_Y1);
  end

  // Pointer only advances on beats dispatched in round-robin mode.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !mode) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

  dmux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load0),
    .d     (i_data),
    .ready (y0_ready),
    .valid (y0_valid),
    .q     (y0_data),
    .free  (free0)
`ifdef DMUX_DISP_CNT_EN
    ,
    .cnt   (cnt0)
`endif
  );

  dmux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load1),
    .d     (i_data),
    .ready (y1_ready),
    .valid (y1_valid),
    .q     (y1_data),
    .free  (free1)
`ifdef DMUX_DISP_CNT_EN
    ,
    .cnt   (cnt1)
`endif
  );

endmodule

// File: tb/tb_dmux_1by2_dispatcher.sv
// tb/tb_dmux_1by2_dispatcher.sv - self-checking bench for dmux_1by2_dispatcher
module tb_dmux_1by2_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       s;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] y0_data;
  logic       y0_valid;
  logic       y0_ready;
  logic [7:0] y1_data;
  logic       y1_valid;
  logic       y1_ready;
  logic       rr_ptr;
`ifdef DMUX_DISP_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what each slot should hold, the pointer, and per-slot
  // queues of beats in arrival order awaiting a consumer handshake.
  logic        m_v[2];
  logic [7:0]  m_d[2];
  logic        m_ptr;
  logic [15:0] m_cnt[2];
  logic [7:0]  sbq0[$];
  logic [7:0]  sbq1[$];
  logic        last_rdy;

  dmux_1by2_dispatcher #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .s        (s),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .y0_data  (y0_data),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .rr_ptr   (rr_ptr)
`ifdef DMUX_DISP_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    m_d[0] = 8'h00; m_d[1] = 8'h00;
    m_ptr = 1'b0;
    m_cnt[0] = 16'h0; m_cnt[1] = 16'h0;
    sbq0.delete();
    sbq1.delete();
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic md,
                       input logic sv, input logic r0, input logic r1);
    logic       t;
    logic       rdy;
    logic       acc;
    logic [7:0] e;
    mode = md; s = sv; i_valid = iv; i_data = d; y0_ready = r0; y1_ready = r1;
    #1;
    t   = md ? sv : m_ptr;
    rdy = t ? (!m_v[1] || r1) : (!m_v[0] || r0);
    acc = iv && rdy;
    last_rdy = i_ready;
    chk("i_ready", i_ready, rdy);
    chk("rr_ptr", rr_ptr, m_ptr);
    if (y0_valid && r0) begin
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        chk("y0_order", y0_data, e);
      end else begin
        chk("y0_unexpected_beat", y0_valid, 1'b0);
      end
    end
    if (y1_valid && r1) begin
      if (sbq1.size() > 0) begin
        e = sbq1.pop_front();
        chk("y1_order", y1_data, e);
      end else begin
        chk("y1_unexpected_beat", y1_valid, 1'b0);
      end
    end
    @(posedge clk);
    if (m_v[0] && r0) begin m_v[0] = 1'b0; m_cnt[0] = m_cnt[0] + 16'd1; end
    if (m_v[1] && r1) begin m_v[1] = 1'b0; m_cnt[1] = m_cnt[1] + 16'd1; end
    if (acc) begin
      m_v[t] = 1'b1;
      m_d[t] = d;
      if (t) sbq1.push_back(d); else sbq0.push_back(d);
      if (!md) m_ptr = ~m_ptr;
    end
    @(negedge clk);
    chk("y0_valid", y0_valid, m_v[0]);
    chk("y1_valid", y1_valid, m_v[1]);
    if (m_v[0]) chk("y0_data", y0_data, m_d[0]);
    if (m_v[1]) chk("y1_data", y1_data, m_d[1]);
`ifdef DMUX_DISP_CNT_EN
    chk("cnt0", cnt0, m_cnt[0]);
    chk("cnt1", cnt1, m_cnt[1]);
`endif
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; mode = 1'b0; s = 1'b0; i_valid = 1'b0; i_data = 8'h00;
    y0_ready = 1'b0; y1_ready = 1'b0; last_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_y0_valid", y0_valid, 1'b0);
    chk("rst_y1_valid", y1_valid, 1'b0);
    chk("rst_y0_data", y0_data, 8'h00);
    chk("rst_y1_data", y1_data, 8'h00);
    chk("rst_rr_ptr", rr_ptr, 1'b0);
    chk("rst_i_ready", i_ready, 1'b1);
`ifdef DMUX_DISP_CNT_EN
    chk("rst_cnt0", cnt0, 16'h0);
    chk("rst_cnt1", cnt1, 16'h0);
`endif
    @(negedge clk);

    // Round-robin at full rate.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rr_first_y0", y0_data, 8'hA1);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rr_first_y1", y1_data, 8'hA2);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rr_second_y0", y0_data, 8'hA3);
    cycle(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rr_second_y1", y1_data, 8'hA4);
    chk("rr_ptr_end", rr_ptr, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // No skipping while slot 0 is blocked.
    cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_i_ready", last_rdy, 1'b0);
    chk("stall_y1_empty", y1_valid, 1'b0);
    cycle(1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("unstall_i_ready", last_rdy, 1'b1);
    chk("unstall_y0_data", y0_data, 8'hB3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Explicit select to slot 1; pointer (now 1) must hold.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h10 + 8'(k), 1'b1, 1'b1, 1'b0, 1'b1);
      chk("sel_y0_idle", y0_valid, 1'b0);
    end
    chk("sel_rr_hold", rr_ptr, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Simultaneous drain and reload of slot 1: no bubble.
    cycle(1'b1, 8'h54, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("nobubble_valid", y1_valid, 1'b1);
    chk("nobubble_data", y1_data, 8'h55);

    // Asynchronous reset while both slots hold beats and the input is stalled.
    cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("prereset_stall", last_rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("areset_y0_valid", y0_valid, 1'b0);
    chk("areset_y1_valid", y1_valid, 1'b0);
    chk("areset_rr_ptr", rr_ptr, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b0; i_valid = 1'b0;
    #1;
    chk("postreset_i_ready", i_ready, 1'b1);
    @(negedge clk);

`ifdef DMUX_DISP_CNT_EN
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cnt0_three", cnt0, 16'd3);
    chk("cnt1_two", cnt1, 16'd2);
    guard = 0;
    while (m_cnt[0] != 16'hFFFF && guard < 70000) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk("cnt0_full", cnt0, 16'hFFFF);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("cnt0_wrap", cnt0, 16'h0000);
`endif

    // Randomized traffic against the reference model.
    guard = 0;
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sb0_drained", sbq0.size(), 0);
    chk("sb1_drained", sbq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
